// File: rtl/mux4_rr_sel.sv
// Round-robin select generator for a 4:1 mux with a valid/ready output handshake.
// Optional grant hold (up to MAX_HOLD back-to-back transfers) via MUX4_RR_SEL_GRANT_HOLD_EN.
module mux4_rr_sel #(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       out_valid,
  output logic [1:0] last_ptr
);

  // Handshake: a transfer happens on a rising edge where out_valid and out_ready
  // are both 1; sel/gnt are held unchanged until then unless req[sel] is withdrawn.

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_n;
  logic [1:0] sel_n, last_ptr_n, base, win;
  logic [3:0] gnt_n;
  logic       valid_n, xfer, rearb, keep;

  // First set bit searching base+1, base+2, base+3, base (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign xfer = out_valid & out_ready;
  assign win  = rr_pick(req, base);

`ifdef MUX4_RR_SEL_GRANT_HOLD_EN
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  assign keep = (state == GRANT) && xfer && req[sel] &&
                (hold_cnt < HOLD_W'(MAX_HOLD - 1));
`else
  wire unused_cfg = (MAX_HOLD + HOLD_W) > 0;
  assign keep = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    sel_n      = sel;
    gnt_n      = gnt;
    valid_n    = out_valid;
    last_ptr_n = last_ptr;
    base       = last_ptr;
    rearb      = 1'b0;
`ifdef MUX4_RR_SEL_GRANT_HOLD_EN
    hold_n     = hold_cnt;
`endif
    case (state)
      IDLE: rearb = |req;
      GRANT: begin
        if (xfer) begin
          // The winner is chosen relative to the transfer just completed.
          last_ptr_n = sel;
          base       = sel;
          rearb      = !keep;
        end else if (!req[sel]) begin
          rearb = 1'b1;
        end
      end
      default: rearb = 1'b0;
    endcase

    if (keep) begin
`ifdef MUX4_RR_SEL_GRANT_HOLD_EN
      hold_n = hold_cnt + 1'b1;
`endif
    end else if (rearb) begin
`ifdef MUX4_RR_SEL_GRANT_HOLD_EN
      hold_n = '0;
`endif
      if (|req) begin
        state_n = GRANT;
        sel_n   = win;
        gnt_n   = 4'b0001 << win;
        valid_n = 1'b1;
      end else begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
        valid_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 2'b00;
      gnt       <= 4'b0000;
      out_valid <= 1'b0;
      last_ptr  <= 2'b11;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      gnt       <= gnt_n;
      out_valid <= valid_n;
      last_ptr  <= last_ptr_n;
    end
  end

`ifdef MUX4_RR_SEL_GRANT_HOLD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_cnt <= '0;
    else     hold_cnt <= hold_n;
  end
`endif

endmodule

// File: doc/mux4_rr_sel.md
Name: mux4_rr_sel

Overview:
- Round-robin select generator that sits directly upstream of the 4-to-1 mux and drives its 2-bit select.
- Arbitrates four request lines, one per mux data input (a0..a3), and presents the winner as `sel` plus a one-hot grant.
- Holds the selection stable until the downstream consumer accepts the muxed output through a valid/ready handshake.
- Guarantees fair, starvation-free access to the shared mux output path.

Parameters:
- MAX_HOLD, 4: maximum consecutive transfers one requester may take while holding the grant. Used only when GRANT_HOLD_EN is defined; legal range 1..15.
- HOLD_W, 4: width of the internal hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  4  request per mux input; bit i requests input a_i
- out_ready  input  1  downstream accepts the current muxed sample
- sel  output  2  select to the 4:1 mux; binary index of the granted input
- gnt  output  4  one-hot grant; gnt[i]=1 when input i is selected
- out_valid  output  1  mux output is valid and held for downstream
- last_ptr  output  2  index of the most recently completed transfer (debug/status)

Behaviour:
- Reset (async, immediate on rst=1):
  - sel=2'b00, gnt=4'b0000, out_valid=0.
  - last_ptr=2'b11, so requester 0 has first priority after reset.
  - FSM=IDLE; hold counter=0.
- State IDLE:
  - out_valid=0, gnt=0; sel holds its previous value.
  - If req!=0 at a clock edge, pick the first set bit searching (last_ptr+1), (last_ptr+2), (last_ptr+3), last_ptr, mod 4.
  - Register the winner into sel/gnt, set out_valid=1, go to GRANT.
  - Latency from req assertion to out_valid is exactly 1 clock.
- State GRANT:
  - out_valid=1; sel and gnt are stable and glitch-free.
  - Transfer occurs on any edge with out_valid=1 and out_ready=1. On transfer, last_ptr<=sel.
  - After a transfer, re-arbitrate in the same edge using the updated pointer, so back-to-back grants have no bubble.
  - If req!=0 after the transfer: stay in GRANT with the new winner.
  - If req==0 after the transfer: go to IDLE and drop out_valid.
- Request withdrawal:
  - If req[sel] deasserts while out_ready=0, no transfer is counted and last_ptr is unchanged.
  - Next edge: re-arbitrate among the remaining requests, or go to IDLE if none remain.
- Stall: while out_ready=0 and req[sel]=1, sel, gnt and out_valid hold indefinitely.
- Single requester: may be granted on consecutive transfers; rotation only skips non-requesting inputs.
- Simultaneous events: if req changes on the same edge as a transfer, the arbitration uses the req value sampled at that edge.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt==0 exactly when out_valid==0.
  - When out_valid=1, gnt == (1<<sel).
- Reset mid-GRANT aborts the grant immediately: outputs return to reset values with no transfer counted, and arbitration restarts from requester 0.

Optional Feature:
- Macro: MUX4_RR_SEL_GRANT_HOLD_EN
- When defined:
  - After a transfer, if req[sel] is still 1 and the hold counter is below MAX_HOLD-1, keep the same grant and increment the counter.
  - Otherwise rotate as normal and clear the counter.
  - The counter also clears on IDLE entry and on any grant change.
- When undefined:
  - Strict rotation after every transfer; no hold counter is synthesized.
  - MAX_HOLD and HOLD_W are ignored.

Test Plan:
- Reset: assert rst mid-simulation with req=4'b1111 -> sel=0, gnt=0, out_valid=0, last_ptr=3 immediately. After release, first grant is gnt=4'b0001 one cycle later.
- Rotation: req=4'b1111, out_ready=1 continuously -> sel sequence 0,1,2,3,0,1 on consecutive cycles, out_valid=1 throughout with no bubble.
- Sparse requests: req=4'b1010, out_ready=1 -> sel alternates 1,3,1,3. Then req=4'b0000 -> out_valid drops the next cycle.
- Stall: req=4'b0100, out_ready=0 for 5 cycles -> sel=2, gnt=4'b0100 stable. Raising out_ready for 1 cycle completes one transfer and last_ptr=2.
- Withdrawal: granted sel=1 with out_ready=0, drop req[1] while req[3]=1 -> next cycle sel=3, last_ptr unchanged.
- Hold (macro defined, MAX_HOLD=3): req=4'b0011, out_ready=1 -> sel sequence 0,0,0,1,1,1,0. With the macro undefined, the same stimulus gives 0,1,0,1.
